// File: rtl/uart_tx_pkg.sv
// Shared encodings for the UART transmit path: FSM states and line levels.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam logic IDLE_LEVEL     = 1'b1;
  localparam int   DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Edge/bit counter for the transmit side; same counting scheme as the receiver
// so both ends agree on where a bit starts and ends.
module uart_tx_bit_timer #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] p_last;

  // A prescale of 0 counts like 1, so every bit lasts at least one cycle.
  assign p_last   = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
  assign bit_done = enable && (edge_cnt == p_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else if (enable) begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first payload, optional parity, one stop bit,
// each held for max(prescale,1) cycles. tx_out and busy are registered.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state, state_nxt;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r, par_typ_r;
  logic [PRESCALE_W-1:0] prescale_r, p_last, edge_cnt, edge_nxt;
  logic [3:0]            bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  bit_done, accept, cnt_clear, tx_d, busy_d;

  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  assign accept    = data_valid && !busy;
  assign p_last    = (prescale_r == '0) ? '0 : prescale_r - PRESCALE_W'(1);
  assign cnt_clear = accept || (state == IDLE) || (bit_done && (state_nxt != state));

  uart_tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (state != IDLE),
    .prescale (prescale_r),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .bit_done (bit_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && (bit_cnt == 4'(DATA_WIDTH - 1)))
                 state_nxt = par_en_r ? PARITY : STOP;
      PARITY:  if (bit_done) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = accept ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the counter/state values that
  // become current at the next edge; busy drops one cycle early in STOP.
  always_comb begin
    edge_nxt = (cnt_clear || bit_done) ? '0 : edge_cnt + PRESCALE_W'(1);
    bit_idx  = cnt_clear ? '0 : IDX_W'(bit_done ? bit_cnt + 4'd1 : bit_cnt);
    tx_d     = IDLE_LEVEL;
    busy_d   = 1'b1;
    case (state_nxt)
      IDLE:    busy_d = 1'b0;
      START:   tx_d   = START_BIT;
      DATA:    tx_d   = data_r[bit_idx];
      PARITY:  tx_d   = parity_bit(data_r, par_typ_r);
      STOP: begin
        tx_d   = STOP_BIT;
        busy_d = (edge_nxt != p_last);
      end
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      tx_out <= IDLE_LEVEL;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tx_out <= tx_d;
      busy   <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r     <= '0;
      par_en_r   <= 1'b0;
      par_typ_r  <= 1'b0;
      prescale_r <= '0;
    end else if (accept) begin
      data_r     <= p_data;
      par_en_r   <= par_en;
      par_typ_r  <= par_typ;
      prescale_r <= prescale;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: stimulus queues expected frames, a line
// monitor decodes each frame from tx_out/busy and compares.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    bit         pen;
    bit         pbit;
    int         p;
    bit         b2b;
    bit         abort;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   mon_active = 1'b0;
  logic line_s [0:1023];
  logic busy_s [0:1023];

  uart_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
  endtask

  task automatic push(input logic [7:0] d, input bit pen, input bit pbit, input int p,
                      input bit b2b, input bit abort);
    exp_t e;
    e.data = d; e.pen = pen; e.pbit = pbit; e.p = p; e.b2b = b2b; e.abort = abort;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge right after the accepting posedge.
  task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                      input logic [5:0] ps, input bit exp_par, input int p,
                      input bit scramble, input bit abort);
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("send_busy_timeout", 1'b0, 32'(n), 32'd2000);
    p_data = d; par_en = pen; par_typ = ptyp; prescale = ps; data_valid = 1'b1;
    push(d, pen, exp_par, p, 1'b0, abort);
    @(negedge clk);
    data_valid = 1'b0;
    if (scramble) begin
      p_data   = ~d;
      par_typ  = ~ptyp;
      prescale = 6'd3;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_active) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("drain_timeout", 1'b0, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : monitor
    exp_t       it;
    int         gap, wait_cyc, len, p, off, bcnt, n;
    bit         aborted, ok, cons;
    logic [7:0] got;
    gap = 0;
    wait_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gap = 0;
      end else if (tx_out) begin
        gap++;
        if (exp_q.size() > 0) begin
          wait_cyc++;
          if (wait_cyc > 3000) begin
            it = exp_q.pop_front();
            check("start_timeout", 1'b0, 32'(tx_out), 32'd0);
            wait_cyc = 0;
          end
        end
      end else if (exp_q.size() == 0) begin
        check("spurious_start", 1'b0, 32'(tx_out), 32'd1);
        n = 0;
        while (!tx_out && !rst && n < 2000) begin
          @(negedge clk);
          n++;
        end
        gap = 0;
      end else begin
        wait_cyc = 0;
        it = exp_q.pop_front();
        mon_active = 1'b1;
        p = it.p;
        len = (10 + int'(it.pen)) * p;
        aborted = 1'b0;
        for (int c = 0; c < len; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          line_s[c] = tx_out;
          busy_s[c] = busy;
        end
        if (aborted) begin
          check("abort_expected", it.abort, 32'(it.abort), 32'd1);
          while (rst) @(negedge clk);
        end else if (it.abort) begin
          check("abort_missing", 1'b0, 32'd0, 32'd1);
        end else begin
          ok = 1'b1;
          for (int k = 0; k < p; k++) if (line_s[k] !== 1'b0) ok = 1'b0;
          check("start_bit", ok, 32'(ok), 32'd1);
          got = '0;
          cons = 1'b1;
          for (int b = 0; b < 8; b++) begin
            got[b] = line_s[p * (b + 1)];
            for (int k = 0; k < p; k++)
              if (line_s[p * (b + 1) + k] !== got[b]) cons = 1'b0;
          end
          check("data_held", cons, 32'(cons), 32'd1);
          check("data_byte", got === it.data, 32'(got), 32'(it.data));
          off = 9 * p;
          if (it.pen) begin
            cons = 1'b1;
            for (int k = 0; k < p; k++) if (line_s[off + k] !== it.pbit) cons = 1'b0;
            check("parity_bit", cons, 32'(line_s[off]), 32'(it.pbit));
            off += p;
          end
          ok = 1'b1;
          for (int k = 0; k < p; k++) if (line_s[off + k] !== 1'b1) ok = 1'b0;
          check("stop_bit", ok, 32'(ok), 32'd1);
          bcnt = 0;
          for (int k = 0; k < len - 1; k++) if (busy_s[k] === 1'b1) bcnt++;
          check("busy_high_cycles", bcnt == len - 1, 32'(bcnt), 32'(len - 1));
          check("busy_last_cycle", busy_s[len - 1] === 1'b0, 32'(busy_s[len - 1]), 32'd0);
          if (it.b2b) check("idle_gap", gap == 0, 32'(gap), 32'd0);
        end
        gap = 0;
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1; data_valid = 1'b0; p_data = '0; par_en = 1'b0; par_typ = 1'b0;
    prescale = 6'd8;
    repeat (3) @(negedge clk);
    check("reset_tx_out", tx_out === 1'b1, 32'(tx_out), 32'd1);
    check("reset_busy", busy === 1'b0, 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx_out", tx_out === 1'b1, 32'(tx_out), 32'd1);

    // Basic frame and both parity senses (0x07: even -> 1, odd -> 0).
    send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 8, 1'b0, 1'b0);
    wait_done();
    send(8'h07, 1'b1, 1'b0, 6'd8, 1'b1, 8, 1'b0, 1'b0);
    wait_done();
    send(8'h07, 1'b1, 1'b1, 6'd8, 1'b0, 8, 1'b0, 1'b0);
    wait_done();

    // Back-to-back: 0x3C held from mid-frame, accepted only in the last stop cycle.
    send(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 8, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    p_data = 8'h3C; data_valid = 1'b1;
    push(8'h3C, 1'b0, 1'b0, 8, 1'b1, 1'b0);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_ignored_cycles", n == 39, 32'(n), 32'd39);
    @(negedge clk);
    data_valid = 1'b0;
    wait_done();

    // Inputs scrambled right after accept; 0xC3 with even parity -> 0.
    send(8'hC3, 1'b1, 1'b0, 6'd8, 1'b0, 8, 1'b1, 1'b0);
    wait_done();

    // Reset during data bit 3 of 0x00.
    send(8'h00, 1'b0, 1'b0, 6'd8, 1'b0, 8, 1'b0, 1'b1);
    repeat (35) @(negedge clk);
    check("pre_reset_line", tx_out === 1'b0, 32'(tx_out), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_tx_out", tx_out === 1'b1, 32'(tx_out), 32'd1);
    check("async_reset_busy", busy === 1'b0, 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    send(8'h55, 1'b0, 1'b0, 6'd8, 1'b0, 8, 1'b0, 1'b0);
    wait_done();

    // Prescale corners: 1 (0xB4 odd parity -> 1), 0 acts as 1, and 32.
    send(8'hB4, 1'b1, 1'b1, 6'd1, 1'b1, 1, 1'b0, 1'b0);
    wait_done();
    send(8'h81, 1'b0, 1'b0, 6'd0, 1'b0, 1, 1'b0, 1'b0);
    wait_done();
    send(8'h6E, 1'b0, 1'b0, 6'd32, 1'b0, 32, 1'b0, 1'b0);
    wait_done();

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
